// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared types and constants for the program loader.
// State encoding, bytes per word and the byte-address shift used by the IRAM.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_SHIFT     = 2;

endpackage

// File: rtl/inst_loader.sv
// inst_loader: packs a length-prefixed little-endian byte stream into 32-bit
// words and writes them to IRAM (is_write/im_addr/im_inst), holding the core.
//   in : clk, rst_n, start, rx_data[7:0], rx_valid
//   out: rx_ready, is_write, im_addr, im_inst, core_hold, load_done,
//        load_err, words_written[H:0]
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int W = 32,
  parameter int H = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         is_write,
  output logic [W-1:0] im_addr,
  output logic [W-1:0] im_inst,
  output logic         core_hold,
  output logic         load_done,
  output logic         load_err,
  output logic [H:0]   words_written
);

  localparam logic [31:0] CAP = 32'd1 << H;
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t         state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]    n_words_q, n_words_d;
  logic [H-1:0]   word_idx_q, word_idx_d;
  logic [H:0]     ww_q, ww_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [W-1:0]   inst_q, inst_d;

  logic           xfer;
  logic           last_byte;
  logic [31:0]    n_new;
  logic [H:0]     ww_inc;

  // Handshake outputs depend only on the state register.
  assign rx_ready  = (state_q == LEN) || (state_q == DATA);
  assign is_write  = (state_q == WRITE);
  assign core_hold = (state_q != DONE);
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERR);

  assign im_addr       = addr_q;
  assign im_inst       = inst_q;
  assign words_written = ww_q;

  assign xfer      = rx_valid && rx_ready;
  assign last_byte = (byte_cnt_q == LAST_BYTE);
  // Little-endian: bytes enter at the top and shift down.
  assign n_new     = {rx_data, n_words_q[31:8]};
  assign ww_inc    = ww_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    n_words_d  = n_words_q;
    word_idx_d = word_idx_q;
    ww_d       = ww_q;
    addr_d     = addr_q;
    inst_d     = inst_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start || state_q == IDLE) begin
          byte_cnt_d = '0;
          word_idx_d = '0;
          ww_d       = '0;
        end
        if (start) state_d = LEN;
      end
      LEN: begin
        if (xfer) begin
          n_words_d  = n_new;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            if (n_new == 32'd0)  state_d = DONE;
            else if (n_new > CAP) state_d = ERR;
            else                 state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          inst_d     = {rx_data, inst_q[W-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            state_d = WRITE;
            addr_d  = W'(word_idx_q) << ADDR_SHIFT;
          end
        end
      end
      WRITE: begin
        ww_d = ww_inc;
        // Index only advances when another word follows, so it never wraps.
        if (32'(ww_inc) == n_words_q) begin
          state_d = DONE;
        end else begin
          state_d    = DATA;
          word_idx_d = word_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      n_words_q  <= '0;
      word_idx_q <= '0;
      ww_q       <= '0;
      addr_q     <= '0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      n_words_q  <= n_words_d;
      word_idx_q <= word_idx_d;
      ww_q       <= ww_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
    end
  end

endmodule
